// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared constants and source numbering for the register-file writeback arbiter.
package regfile_writeback_arbiter_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned NSRC      = 3;

    typedef enum logic [1:0] {
        SRC_ALU    = 2'd0,
        SRC_LOAD   = 2'd1,
        SRC_MULDIV = 2'd2
    } src_e;

endpackage

// File: rtl/regfile_writeback_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping.
module regfile_writeback_arbiter_rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic          hi_found, lo_found;
    logic [IW-1:0] hi_idx, lo_idx;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        any = hi_found | lo_found;
        idx = hi_found ? hi_idx : lo_idx;
        gnt = '0;
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Sole writer of the integer register file: round-robin result collection, registered
// write port and per-register busy scoreboard.
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int unsigned NSRC = regfile_writeback_arbiter_pkg::NSRC,
    parameter int unsigned XLEN = regfile_writeback_arbiter_pkg::XLEN,
    parameter int unsigned NREG = regfile_writeback_arbiter_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC-1:0]      src_valid,
    output logic [NSRC-1:0]      src_ready,
    input  logic [NSRC*$clog2(NREG)-1:0] src_rd,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic                 issue_valid,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    output logic [NREG-1:0]      busy,
    output logic                 rf_we,
    output logic [$clog2(NREG)-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_wd
);

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [NSRC-1:0] gnt;
    logic            gnt_any;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_wd;
    logic            rf_we_q, rf_we_d;
    logic [RW-1:0]   rf_rd_q;
    logic [XLEN-1:0] rf_wd_q;
    logic [NREG-1:0] busy_q, busy_d;

    regfile_writeback_arbiter_rr_arbiter #(
        .N  (NSRC),
        .IW (PW)
    ) u_rr_arbiter (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // The register file never back-pressures, so a grant is an accept.
    assign src_ready = rst ? gnt : '0;

    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt[i]) begin
                sel_rd = src_rd[i*RW +: RW];
                sel_wd = src_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == PW'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
        end
        // x0 results are accepted but never written.
        rf_we_d = gnt_any && (sel_rd != '0);
    end

    // Set wins over clear: an issue on the commit edge names a new pending producer.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            rf_we_q  <= 1'b0;
            rf_rd_q  <= '0;
            rf_wd_q  <= '0;
            busy_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rf_we_q  <= rf_we_d;
            busy_q   <= busy_d;
            if (gnt_any) begin
                rf_rd_q <= sel_rd;
                rf_wd_q <= sel_wd;
            end
        end
    end

    assign rf_we = rf_we_q;
    assign rf_rd = rf_rd_q;
    assign rf_wd = rf_wd_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed vector table, async-reset sequence and
// randomized traffic against a behavioural model.
module tb_regfile_writeback_arbiter;
    import regfile_writeback_arbiter_pkg::*;

    localparam int NS = 3;
    localparam int XW = 32;
    localparam int NR = 32;
    localparam int RW = REG_IDX_W;

    logic            clk;
    logic            rst;
    logic [NS-1:0]   src_valid;
    logic [NS-1:0]   src_ready;
    logic [NS*RW-1:0] src_rd;
    logic [NS*XW-1:0] src_data;
    logic            issue_valid;
    logic [RW-1:0]   issue_rd;
    logic [NR-1:0]   busy;
    logic            rf_we;
    logic [RW-1:0]   rf_rd;
    logic [XW-1:0]   rf_wd;

    int tests = 0;
    int fails = 0;

    regfile_writeback_arbiter #(
        .NSRC (NS),
        .XLEN (XW),
        .NREG (NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_rd      (src_rd),
        .src_data    (src_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wd       (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  r0, r1, r2;
        logic [31:0] d0, d1, d2;
        logic        iv;
        logic [4:0]  ird;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic [2:0] v, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic iv,
                                logic [4:0] ird, logic [2:0] er, logic ew, logic [4:0] erd,
                                logic [31:0] ewd, logic [31:0] eb);
        vec_t t;
        t.v = v; t.r0 = r0; t.r1 = r1; t.r2 = r2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2;
        t.iv = iv; t.ird = ird;
        t.e_ready = er; t.e_we = ew; t.e_rd = erd; t.e_wd = ewd; t.e_busy = eb;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic iv, input logic [4:0] ird);
        src_valid   = v;
        src_rd      = {r2, r1, r0};
        src_data    = {d2, d1, d0};
        issue_valid = iv;
        issue_rd    = ird;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Behavioural model state
    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic [31:0] m_busy;

    localparam logic [31:0] A = 32'hA000_000A;
    localparam logic [31:0] B = 32'hB000_000B;
    localparam logic [31:0] C = 32'hC000_000C;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        #2;
        check("reset_we", {31'd0, rf_we}, 32'd0);
        check("reset_busy", busy, 32'd0);
        check("reset_ready", {29'd0, src_ready}, 32'd0);

        // Round-robin with all three sources valid, then single write, x0 drop, scoreboard.
        vecs[0]  = mk(3'b111, 1, 2, 3, A, B, C, 0, 0, 3'b001, 1, 1, A, 0);
        vecs[1]  = mk(3'b111, 1, 2, 3, A, B, C, 0, 0, 3'b010, 1, 2, B, 0);
        vecs[2]  = mk(3'b111, 1, 2, 3, A, B, C, 0, 0, 3'b100, 1, 3, C, 0);
        vecs[3]  = mk(3'b111, 1, 2, 3, A, B, C, 0, 0, 3'b001, 1, 1, A, 0);
        vecs[4]  = mk(3'b111, 1, 2, 3, A, B, C, 0, 0, 3'b010, 1, 2, B, 0);
        vecs[5]  = mk(3'b111, 1, 2, 3, A, B, C, 0, 0, 3'b100, 1, 3, C, 0);
        vecs[6]  = mk(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 3'b001, 1, 5, 32'hDEADBEEF, 0);
        vecs[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5, 32'hDEADBEEF, 0);
        vecs[8]  = mk(3'b010, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 3'b010, 0, 0, 32'h1234, 0);
        vecs[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 3'b000, 0, 0, 32'h1234, 32'h80);
        vecs[10] = mk(3'b100, 0, 0, 7, 0, 0, 32'h77, 0, 0, 3'b100, 1, 7, 32'h77, 32'h80);
        vecs[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 7, 32'h77, 0);
        vecs[12] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 3'b000, 0, 7, 32'h77, 32'h200);
        vecs[13] = mk(3'b001, 9, 0, 0, 32'h99, 0, 0, 0, 0, 3'b001, 1, 9, 32'h99, 32'h200);
        vecs[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 3'b000, 0, 9, 32'h99, 32'h200);
        vecs[15] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 9, 32'h99, 32'h200);
        vecs[16] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 9, 32'h99, 32'h200);

        do_reset();
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive(vecs[k].v, vecs[k].r0, vecs[k].r1, vecs[k].r2,
                  vecs[k].d0, vecs[k].d1, vecs[k].d2, vecs[k].iv, vecs[k].ird);
            #1;
            check($sformatf("vec%0d_ready", k), {29'd0, src_ready}, {29'd0, vecs[k].e_ready});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_we", k), {31'd0, rf_we}, {31'd0, vecs[k].e_we});
            check($sformatf("vec%0d_rd", k), {27'd0, rf_rd}, {27'd0, vecs[k].e_rd});
            check($sformatf("vec%0d_wd", k), rf_wd, vecs[k].e_wd);
            check($sformatf("vec%0d_busy", k), busy, vecs[k].e_busy);
        end

        // Async reset while a write is pending; pointer sits at 1 beforehand.
        @(negedge clk);
        drive(3'b001, 5'd12, 5'd0, 5'd0, 32'h5555AAAA, 32'd0, 32'd0, 1'b1, 5'd4);
        @(posedge clk);
        #1;
        check("pre_rst_we", {31'd0, rf_we}, 32'd1);
        check("pre_rst_busy", busy, 32'h0000_0210);
        @(negedge clk);
        drive(3'b111, 5'd1, 5'd2, 5'd3, A, B, C, 1'b0, 5'd0);
        #1;
        rst = 1'b0;
        #1;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_rd", {27'd0, rf_rd}, 32'd0);
        check("rst_wd", rf_wd, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_ready", {29'd0, src_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_ready", {29'd0, src_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_rd", {27'd0, rf_rd}, 32'd1);

        // Randomized traffic against the model.
        do_reset();
        m_ptr = 0; m_we = 1'b0; m_rd = '0; m_wd = '0; m_busy = '0;
        begin
            logic [2:0]  v;
            logic [4:0]  r[3];
            logic [31:0] d[3];
            logic        iv;
            logic [4:0]  ird;
            int          g;
            int          g_prev;
            v = '0;
            g_prev = -1;
            for (int i = 0; i < 3; i++) begin
                r[i] = '0;
                d[i] = '0;
            end
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                // Sources keep their offer stable until it is accepted.
                for (int i = 0; i < 3; i++) begin
                    if (!v[i] || g_prev == i) begin
                        v[i] = ($urandom_range(0, 9) < 6);
                        r[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                        d[i] = $urandom;
                    end
                end
                iv  = ($urandom_range(0, 2) == 0);
                ird = 5'($urandom_range(0, 31));
                drive(v, r[0], r[1], r[2], d[0], d[1], d[2], iv, ird);

                g = -1;
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && v[(m_ptr + k) % 3]) begin
                        g = (m_ptr + k) % 3;
                    end
                end
                #1;
                check($sformatf("rnd%0d_ready", cyc), {29'd0, src_ready},
                      (g >= 0) ? (32'd1 << g) : 32'd0);

                @(posedge clk);
                if (m_we) m_busy[m_rd] = 1'b0;
                if (iv && ird != 0) m_busy[ird] = 1'b1;
                if (g >= 0) begin
                    m_rd  = r[g];
                    m_wd  = d[g];
                    m_we  = (r[g] != 0);
                    m_ptr = (g + 1) % 3;
                end else begin
                    m_we = 1'b0;
                end
                g_prev = g;
                #1;
                check($sformatf("rnd%0d_we", cyc), {31'd0, rf_we}, {31'd0, m_we});
                check($sformatf("rnd%0d_rd", cyc), {27'd0, rf_rd}, {27'd0, m_rd});
                check($sformatf("rnd%0d_wd", cyc), rf_wd, m_wd);
                check($sformatf("rnd%0d_busy", cyc), busy, m_busy);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
Sole writer to the integer register file's single write port. It collects completed results from NSRC execution sources (ALU, load unit, mul/div) over valid/ready handshakes. It arbitrates among them round-robin and drives a registered write (we, rd, data) into the register file one cycle later. It also keeps a per-register busy scoreboard: issue sets a bit, the committed write clears it. The decode/hazard logic uses the scoreboard to stall readers.

Parameters:
NSRC, 3, number of result sources (index 0 = ALU, 1 = load, 2 = mul/div).
XLEN, 32, data width.
NREG, 32, architectural registers; index width is $clog2(NREG) = 5.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low.
src_valid  input  NSRC  source i holds a result.
src_ready  output  NSRC  source i's result is accepted this cycle.
src_rd  input  NSRC*5  destination of source i, packed, source i at bits [5i+4:5i].
src_data  input  NSRC*XLEN  result of source i, packed likewise.
issue_valid  input  1  an instruction with a destination is issued this cycle.
issue_rd  input  5  destination of the issued instruction.
busy  output  NREG  scoreboard, busy[r]=1 means a write to r is pending.
rf_we  output  1  register-file write enable, registered.
rf_rd  output  5  register-file write index, registered.
rf_wd  output  XLEN  register-file write data, registered.

Behaviour:
- Reset (rst=0, async): rf_we=0, rf_rd=0, rf_wd=0, busy=0, round-robin pointer rr_ptr=0. src_ready=0 while in reset.
- Arbitration (combinational):
  - Search from rr_ptr upward, modulo NSRC, for the first i with src_valid[i]=1.
  - At most one src_ready bit is high per cycle. src_ready[i]=1 only if src_valid[i]=1.
  - No dependency of src_ready on any downstream back-pressure: the register file always accepts.
- Transfer: occurs when src_valid[i] and src_ready[i] are both 1 at a rising edge.
  - At that edge, rf_rd <= src_rd[i] and rf_wd <= src_data[i].
  - rf_we <= 1 if src_rd[i] != 0, else rf_we <= 0 (writes to x0 are consumed and dropped).
  - Latency: accept edge to register-file capture is exactly 1 cycle, sustaining 1 write per cycle.
- No transfer in a cycle: rf_we <= 0. rf_rd and rf_wd hold their last values.
- Pointer update: after a grant to i, rr_ptr <= (i+1) mod NSRC. With no grant, rr_ptr is unchanged.
  - Consequence: a continuously valid source is starved for at most NSRC-1 cycles.
- Sources must hold src_valid, src_rd and src_data stable until accepted. The block does not check this.
- Scoreboard, per register r, each edge:
  - Set when issue_valid=1 and issue_rd=r.
  - Clear when rf_we=1 and rf_rd=r, i.e. the edge at which the register file captures the data.
  - Set and clear on the same r in the same edge: set wins, because the new producer is pending.
  - Otherwise hold.
  - busy[0] is constant 0. Issue to x0 is ignored.
- Re-issue to an already busy r leaves busy=1. The first writeback clears it. The scoreboard tracks one outstanding producer per register; decode must stall a WAW issue. This is an allowed-use rule, not checked.
- Reset mid-transfer: a pending rf_we is cancelled immediately (async). The result is lost and the source must be flushed by its own reset.

Decomposition:
- Shared package: constants REG_IDX_W=5, XLEN, NREG, and source index enumerants SRC_ALU=0, SRC_LOAD=1, SRC_MULDIV=2.
- One sub-module: rr_arbiter (parameterised N; inputs req[N] and ptr; output one-hot gnt[N] plus encoded index). Pointer state stays in the top.
- Scoreboard and write register live in the top.

Test Plan:
- Reset: drive rst=0 mid-sim while rf_we=1 -> rf_we, rf_rd, rf_wd, busy read 0 immediately; after release the first grant goes to source 0.
- Single write: src_valid[0]=1, rd=5, data=0xDEADBEEF at edge N -> src_ready[0]=1 in that cycle; rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF after edge N; rf_we=0 after edge N+1.
- Round-robin: all three sources valid continuously with rd=1,2,3 -> grants in order 0,1,2,0,1,2; rf_rd sequence 1,2,3,1,2,3; never two src_ready bits high.
- x0 drop: source 1 valid with rd=0, data=0x1234 -> src_ready[1]=1, rf_we stays 0, busy unchanged.
- Scoreboard: issue rd=7 -> busy[7]=1 next cycle; source 2 writes rd=7 -> busy[7] clears at the edge rf_we=1.
- Same-edge set/clear: issue rd=9 on the same edge the pending write to 9 commits -> busy[9] remains 1. issue_rd=0 -> busy[0] stays 0.
